whack_event_encoder: RTL and testbench
======================================

# whack_event_encoder

Turns raw hole-switch activity into a serialized stream of whack events (hit / miss / full-clear hit) with a valid/ready handshake. It is the transmitting end of the hit-event interface feeding the combo counter. It sits between the board switches, the mole generator's `mole_positions`, and the event consumer. It also owns the "moles still up" mask that drives the LEDs.

## Interface
- `NUM_HOLES`, 18, number of holes / switches / LEDs
- `IDX_W`, $clog2(NUM_HOLES) = 5, width of a hole index
- `clk`  in  1  system clock (50 MHz)
- `rst_n`  in  1  asynchronous active-low reset
- `enable`  in  1  game in progress; gates event capture and mask loads
- `switches`  in  NUM_HOLES  raw, unsynchronized slide switches
- `mole_positions`  in  NUM_HOLES  new mole set from the generator
- `mole_load`  in  1  one-cycle pulse: sample `mole_positions` into the active mask
- `ev_valid`  out  1  event on `ev_hole`/`ev_kind` is valid
- `ev_ready`  in  1  consumer accepts the event this cycle
- `ev_hole`  out  IDX_W  hole index of the event
- `ev_kind`  out  2  EV_HIT=00, EV_MISS=01, EV_FULL_CLEAR=10
- `leds`  out  NUM_HOLES  active mask (moles still up)
- `round_done`  out  1  one-cycle pulse when hits empty a nonzero mask

## Operation
- **Input capture**
  - `switches` pass through a 2-flop synchronizer, then a previous-value register.
  - A toggle is any change (either direction) of a synchronized bit.
- **Priming after reset**
  - A `primed` flag sets on the 3rd clock edge after reset release.
  - Before `primed`, the previous-value register only tracks; no toggles are recognized.
  - Switches already up at reset therefore never create events.
- **Classification** (toggle at hole i, `enable`=1), always against the pre-update active mask:
  - `active[i]`=1: clear `active[i]` and set `hit_pend[i]`.
  - `active[i]`=0: set `miss_pend[i]`.
- **Full clear**
  - Applies when that cycle's hits take `active` from nonzero to zero.
  - The lowest-index hit of that cycle goes to `fc_pend` instead of `hit_pend`; `round_done` pulses.
- **Merging**: a toggle landing on an already-set bit of the same bitmap is merged and produces no second event.
- **Mask load**
  - `mole_load` with `enable`=1 sets `active <= mole_positions`.
  - If a toggle lands in the same cycle, it is classified against the old mask, then the new mask wins.
  - No `round_done` pulse in a load cycle.
- **Enable low**
  - Toggles are tracked but discarded, and `mole_load` is ignored.
  - Pending events keep draining.
- **Serializer (output arbitration)**
  - Order: lowest index in `fc_pend|hit_pend` first (fc wins if both are set for a hole), then lowest index in `miss_pend`.
  - The selected event loads the output register when `!ev_valid || ev_ready`, and its pending bit clears on that same edge.
- **Handshake**
  - `ev_hole`/`ev_kind` stay stable while `ev_valid && !ev_ready`.
  - `ev_valid` drops only after acceptance with nothing pending.
- **Outputs**: `leds = active`.
- **Reset values**: all registers 0, so `ev_valid`=0, `ev_hole`=0, `ev_kind`=00, `leds`=0, `round_done`=0.

## Timing
- **Switch-to-event latency**: toggle visible on the pin before edge 0 gives `sync1` @0, `sync2` @1, pending bit @2, `ev_valid` @3, when the output is empty or being accepted.
- **Throughput**: 1 event/cycle with `ev_ready` held high.
- **Back-pressure**: unbounded in time, bounded in space. At most 3 pending events per hole (hit, fc, miss); further toggles merge.
- **`mole_load`**: the mask updates on the same edge; `leds` reflect it the next cycle.
- **`round_done`**: asserted the cycle after the clearing edge, exactly one cycle wide.
- **`rst_n` low mid-stream**: everything clears immediately (async); pending events are lost and `ev_valid` drops without handshake.

## Structure
- Package `whack_pkg` holds:
  - `ev_kind_t` enum (EV_HIT, EV_MISS, EV_FULL_CLEAR)
  - `NUM_HOLES` default 18
  - `SYNC_STAGES`=2
- Sub-module `hole_priority_encoder` (combinational, parameterized by `NUM_HOLES`): bitmap in; `found` plus lowest set `index` out. Instantiated twice (hit/fc bitmap, miss bitmap).
- Everything else lives in the top: synchronizer, edge detect, bitmaps, active mask, output register.

## Test plan
- **Reset with switches up**: SW=18'h3FFFF at reset, release, hold 20 cycles -> `ev_valid` stays 0, `leds`=0.
- **Basic hit and miss**: load positions 18'h00005, toggle SW[2], `ev_ready`=1 -> `ev_valid` 3 edges later with hole=2, kind=EV_HIT, `leds`=18'h00001; then toggle SW[7] -> hole=7, kind=EV_MISS.
- **Full clear**: positions 18'h00011, toggle SW[0] and SW[4] in the same cycle -> EV_FULL_CLEAR on hole 0, then EV_HIT on hole 4, `round_done` one pulse, `leds`=0.
- **Back-pressure**: `ev_ready`=0, toggle SW[9], SW[3], SW[12] (none active) -> `ev_valid` held with hole=3 stable; raise `ev_ready` -> holes 3, 9, 12 on consecutive cycles, then `ev_valid`=0.
- **Load collision**: positions 18'h00002, same cycle `mole_load` with 18'h00008 and a toggle on SW[1] -> EV_HIT hole 1, `leds`=18'h00008, no `round_done`.
- **Enable low and async reset**: `enable`=0 plus toggles -> no events. Mid-drain `rst_n` pulse -> `ev_valid`=0 immediately, nothing emitted after release.

Source files
------------

// File: rtl/whack_event_encoder_pkg.sv
// Shared types and defaults for the whack event encoder slice.
package whack_pkg;

    localparam int NUM_HOLES   = 18;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        EV_HIT        = 2'b00,
        EV_MISS       = 2'b01,
        EV_FULL_CLEAR = 2'b10
    } ev_kind_t;

endpackage

// File: rtl/hole_priority_encoder.sv
// Combinational lowest-set-bit finder over a hole bitmap.
module hole_priority_encoder #(
    parameter int NUM_HOLES = 18,
    parameter int IDX_W     = $clog2(NUM_HOLES)
) (
    input  logic [NUM_HOLES-1:0] bitmap,
    output logic                 found,
    output logic [IDX_W-1:0]     index
);

    always_comb begin
        found = 1'b0;
        index = '0;
        for (int unsigned i = 0; i < NUM_HOLES; i++) begin
            if (!found && bitmap[i]) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/whack_event_encoder.sv
// Converts hole-switch toggles into serialized hit / miss / full-clear events
// and owns the active mole mask shown on the LEDs.
module whack_event_encoder #(
    parameter int NUM_HOLES = whack_pkg::NUM_HOLES,
    parameter int IDX_W     = $clog2(NUM_HOLES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NUM_HOLES-1:0] switches,
    input  logic [NUM_HOLES-1:0] mole_positions,
    input  logic                 mole_load,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [IDX_W-1:0]     ev_hole,
    output logic [1:0]           ev_kind,
    output logic [NUM_HOLES-1:0] leds,
    output logic                 round_done
);

    import whack_pkg::*;

    logic [NUM_HOLES-1:0] sync_q [SYNC_STAGES];
    logic [NUM_HOLES-1:0] sw_sync;
    logic [NUM_HOLES-1:0] sw_prev;
    logic [1:0]           prime_cnt;
    logic                 primed;

    logic [NUM_HOLES-1:0] active;
    logic [NUM_HOLES-1:0] hit_pend;
    logic [NUM_HOLES-1:0] fc_pend;
    logic [NUM_HOLES-1:0] miss_pend;

    logic [NUM_HOLES-1:0] toggle;
    logic [NUM_HOLES-1:0] hit_new;
    logic [NUM_HOLES-1:0] miss_new;
    logic [NUM_HOLES-1:0] fc_new;
    logic [NUM_HOLES-1:0] active_left;
    logic                 load_now;
    logic                 full_clear;

    logic                 hf_found;
    logic [IDX_W-1:0]     hf_idx;
    logic                 miss_found;
    logic [IDX_W-1:0]     miss_idx;

    logic                 out_load;
    logic                 ev_take;
    logic [IDX_W-1:0]     sel_idx;
    ev_kind_t             sel_kind;
    logic [NUM_HOLES-1:0] hit_clr;
    logic [NUM_HOLES-1:0] fc_clr;
    logic [NUM_HOLES-1:0] miss_clr;

    logic                 ev_valid_q;
    logic [IDX_W-1:0]     ev_hole_q;
    ev_kind_t             ev_kind_q;
    logic                 round_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            sw_prev   <= '0;
            prime_cnt <= '0;
            primed    <= 1'b0;
        end else begin
            sync_q[0] <= switches;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            sw_prev <= sw_sync;
            // primed rises on the third edge so reset-time switch levels settle into sw_prev first
            if (!primed) begin
                if (prime_cnt == 2'd2) begin
                    primed <= 1'b1;
                end else begin
                    prime_cnt <= prime_cnt + 2'd1;
                end
            end
        end
    end

    assign sw_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        toggle      = (primed && enable) ? (sw_sync ^ sw_prev) : '0;
        load_now    = enable && mole_load;
        hit_new     = toggle & active;
        miss_new    = toggle & ~active;
        active_left = active & ~hit_new;
        full_clear  = (|hit_new) && !(|active_left) && !load_now;
        // isolate the lowest-index hit of the clearing cycle
        fc_new      = full_clear ? (hit_new & (~hit_new + NUM_HOLES'(1))) : '0;
    end

    hole_priority_encoder #(
        .NUM_HOLES (NUM_HOLES),
        .IDX_W     (IDX_W)
    ) u_hf_enc (
        .bitmap (fc_pend | hit_pend),
        .found  (hf_found),
        .index  (hf_idx)
    );

    hole_priority_encoder #(
        .NUM_HOLES (NUM_HOLES),
        .IDX_W     (IDX_W)
    ) u_miss_enc (
        .bitmap (miss_pend),
        .found  (miss_found),
        .index  (miss_idx)
    );

    always_comb begin
        out_load = !ev_valid_q || ev_ready;
        ev_take  = 1'b0;
        sel_idx  = '0;
        sel_kind = EV_HIT;
        hit_clr  = '0;
        fc_clr   = '0;
        miss_clr = '0;
        if (out_load) begin
            if (hf_found) begin
                ev_take = 1'b1;
                sel_idx = hf_idx;
                if (fc_pend[hf_idx]) begin
                    sel_kind = EV_FULL_CLEAR;
                    fc_clr   = NUM_HOLES'(1) << hf_idx;
                end else begin
                    sel_kind = EV_HIT;
                    hit_clr  = NUM_HOLES'(1) << hf_idx;
                end
            end else if (miss_found) begin
                ev_take  = 1'b1;
                sel_idx  = miss_idx;
                sel_kind = EV_MISS;
                miss_clr = NUM_HOLES'(1) << miss_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active       <= '0;
            hit_pend     <= '0;
            fc_pend      <= '0;
            miss_pend    <= '0;
            round_done_q <= 1'b0;
            ev_valid_q   <= 1'b0;
            ev_hole_q    <= '0;
            ev_kind_q    <= EV_HIT;
        end else begin
            active       <= load_now ? mole_positions : active_left;
            hit_pend     <= (hit_pend & ~hit_clr) | (hit_new & ~fc_new);
            fc_pend      <= (fc_pend & ~fc_clr) | fc_new;
            miss_pend    <= (miss_pend & ~miss_clr) | miss_new;
            round_done_q <= full_clear;
            if (out_load) begin
                ev_valid_q <= ev_take;
                if (ev_take) begin
                    ev_hole_q <= sel_idx;
                    ev_kind_q <= sel_kind;
                end
            end
        end
    end

    assign ev_valid   = ev_valid_q;
    assign ev_hole    = ev_hole_q;
    assign ev_kind    = ev_kind_q;
    assign leds       = active;
    assign round_done = round_done_q;

endmodule

// File: tb/tb_whack_event_encoder.sv
// Scoreboard bench for whack_event_encoder: a per-hole reference model
// predicts events into a queue that a negedge monitor checks.
module tb_whack_event_encoder;

    localparam int N = 18;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [N-1:0]  switches;
    logic [N-1:0]  mole_positions;
    logic          mole_load;
    logic          ev_valid;
    logic          ev_ready;
    logic [4:0]    ev_hole;
    logic [1:0]    ev_kind;
    logic [N-1:0]  leds;
    logic          round_done;

    int checks = 0;
    int errors = 0;

    whack_event_encoder #(.NUM_HOLES(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .switches       (switches),
        .mole_positions (mole_positions),
        .mole_load      (mole_load),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_hole        (ev_hole),
        .ev_kind        (ev_kind),
        .leds           (leds),
        .round_done     (round_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hole;
        int kind;
    } ev_t;

    ev_t q[$];

    // reference model state, one entry per hole
    bit [N-1:0] m_s1, m_s2, m_prev, m_act;
    bit         m_hit [N];
    bit         m_fc  [N];
    bit         m_miss[N];
    bit         m_primed;
    int         m_cnt;
    bit         m_valid;
    bit         m_rd;

    bit [N-1:0] t_tog;
    int         t_sel, t_kind, t_first, t_nhits;
    bit         t_fc, t_load;
    ev_t        t_ev;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_prev = '0; m_act = '0;
            for (int i = 0; i < N; i++) begin
                m_hit[i] = 0; m_fc[i] = 0; m_miss[i] = 0;
            end
            m_primed = 0; m_cnt = 0; m_valid = 0; m_rd = 0;
            q.delete();
        end else begin
            t_tog  = (m_primed && enable) ? (m_s2 ^ m_prev) : '0;
            t_load = mole_load && enable;
            if (!m_valid || ev_ready) begin
                t_sel = -1;
                for (int i = 0; i < N; i++)
                    if (t_sel < 0 && (m_fc[i] || m_hit[i])) begin
                        t_sel = i;
                        t_kind = m_fc[i] ? 2 : 0;
                    end
                if (t_sel < 0)
                    for (int i = 0; i < N; i++)
                        if (t_sel < 0 && m_miss[i]) begin
                            t_sel = i;
                            t_kind = 1;
                        end
                if (t_sel >= 0) begin
                    t_ev.hole = t_sel;
                    t_ev.kind = t_kind;
                    q.push_back(t_ev);
                    m_valid = 1;
                    if (t_kind == 2) m_fc[t_sel] = 0;
                    else if (t_kind == 0) m_hit[t_sel] = 0;
                    else m_miss[t_sel] = 0;
                end else begin
                    m_valid = 0;
                end
            end
            t_first = -1;
            t_nhits = 0;
            for (int i = 0; i < N; i++)
                if (t_tog[i]) begin
                    if (m_act[i]) begin
                        t_nhits++;
                        if (t_first < 0) t_first = i;
                    end else begin
                        m_miss[i] = 1;
                    end
                end
            t_fc = (t_nhits > 0) && (t_nhits == $countones(m_act)) && !t_load;
            for (int i = 0; i < N; i++)
                if (t_tog[i] && m_act[i]) begin
                    if (t_fc && i == t_first) m_fc[i] = 1;
                    else m_hit[i] = 1;
                end
            m_rd  = t_fc;
            m_act = t_load ? mole_positions : (m_act & ~t_tog);
            m_prev = m_s2;
            m_s2   = m_s1;
            m_s1   = switches;
            if (!m_primed) begin
                if (m_cnt == 2) m_primed = 1;
                else m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_valid", int'(ev_valid), 0);
            chk("reset_leds", int'(leds), 0);
        end else begin
            chk("ev_valid", int'(ev_valid), int'(m_valid));
            chk("leds", int'(leds), int'(m_act));
            chk("round_done", int'(round_done), int'(m_rd));
            if (ev_valid && m_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: got hole %0d with no expected event", ev_hole);
                end else begin
                    chk("ev_hole", int'(ev_hole), q[0].hole);
                    chk("ev_kind", int'(ev_kind), q[0].kind);
                    if (ev_ready) void'(q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic flip(input int k);
        switches[k] = ~switches[k];
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        enable = 1'b1;
        switches = '1;
        mole_positions = '0;
        mole_load = 1'b0;
        ev_ready = 1'b1;

        // switches up through reset never produce events
        tick(3);
        rst_n = 1'b1;
        tick(20);
        chk("sw_up_valid", int'(ev_valid), 0);
        chk("sw_up_leds", int'(leds), 0);
        enable = 1'b0;
        switches = '0;
        tick(4);
        enable = 1'b1;

        // basic hit then miss
        mole_positions = 18'h00005;
        mole_load = 1'b1;
        tick();
        mole_load = 1'b0;
        flip(2);
        tick(4);
        chk("basic_valid", int'(ev_valid), 1);
        chk("basic_hole", int'(ev_hole), 2);
        chk("basic_kind", int'(ev_kind), 0);
        chk("basic_leds", int'(leds), 1);
        tick(2);
        flip(7);
        tick(4);
        chk("miss_hole", int'(ev_hole), 7);
        chk("miss_kind", int'(ev_kind), 1);
        tick(3);

        // full clear with two simultaneous hits
        mole_positions = 18'h00011;
        mole_load = 1'b1;
        tick();
        mole_load = 1'b0;
        flip(0);
        flip(4);
        tick(3);
        chk("fc_round_done", int'(round_done), 1);
        chk("fc_leds", int'(leds), 0);
        tick();
        chk("fc_hole", int'(ev_hole), 0);
        chk("fc_kind", int'(ev_kind), 2);
        chk("fc_rd_width", int'(round_done), 0);
        tick();
        chk("fc_hit_hole", int'(ev_hole), 4);
        chk("fc_hit_kind", int'(ev_kind), 0);
        tick(3);

        // back-pressure on three misses
        ev_ready = 1'b0;
        flip(9);
        flip(3);
        flip(12);
        tick(4);
        chk("bp_hole", int'(ev_hole), 3);
        tick(4);
        chk("bp_hold_valid", int'(ev_valid), 1);
        chk("bp_hold_hole", int'(ev_hole), 3);
        ev_ready = 1'b1;
        tick();
        chk("bp_next", int'(ev_hole), 9);
        tick();
        chk("bp_last", int'(ev_hole), 12);
        tick();
        chk("bp_empty", int'(ev_valid), 0);

        // toggle classified against the old mask while a new mask loads
        mole_positions = 18'h00002;
        mole_load = 1'b1;
        tick();
        mole_load = 1'b0;
        flip(1);
        tick(2);
        mole_positions = 18'h00008;
        mole_load = 1'b1;
        tick();
        mole_load = 1'b0;
        chk("coll_leds", int'(leds), 8);
        chk("coll_round_done", int'(round_done), 0);
        tick();
        chk("coll_hole", int'(ev_hole), 1);
        chk("coll_kind", int'(ev_kind), 0);
        tick(3);

        // enable low discards toggles and loads
        enable = 1'b0;
        flip(3);
        flip(8);
        flip(15);
        mole_positions = 18'h3F000;
        mole_load = 1'b1;
        tick();
        mole_load = 1'b0;
        tick(6);
        chk("en_low_valid", int'(ev_valid), 0);
        chk("en_low_leds", int'(leds), 8);
        enable = 1'b1;

        // async reset mid-drain
        ev_ready = 1'b0;
        flip(5);
        flip(6);
        flip(10);
        tick(5);
        rst_n = 1'b0;
        #1;
        chk("async_valid", int'(ev_valid), 0);
        chk("async_leds", int'(leds), 0);
        tick();
        rst_n = 1'b1;
        ev_ready = 1'b1;
        tick(10);
        chk("post_reset_valid", int'(ev_valid), 0);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            enable = ($urandom_range(0, 9) != 0);
            ev_ready = ($urandom_range(0, 9) < 7);
            mole_load = ($urandom_range(0, 7) == 0);
            mole_positions = 18'($urandom) & 18'($urandom) & 18'($urandom);
            if ($urandom_range(0, 2) == 0 && m_act != '0) begin
                k = 0;
                while (!m_act[k]) k++;
                flip(k);
            end
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, N - 1);
                flip(k);
            end
            if (c == 700) begin
                rst_n = 1'b0;
                #1;
                chk("rand_reset_valid", int'(ev_valid), 0);
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        // drain with a bounded wait
        mole_load = 1'b0;
        enable = 1'b1;
        ev_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (q.size() == 0 && !ev_valid) break;
            tick();
        end
        tick(4);
        chk("drain_valid", int'(ev_valid), 0);
        chk("drain_queue", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
